// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM block.
// Holds the mode and direction encodings and the duty-bus slice helper.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // LSB position of channel ch inside the flattened duty bus.
    function automatic int duty_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active duty and polarity, compare, output flop.
// Ports: clk, reset, enable, count, load_shadow, transfer, duty_in, pol_in -> pwm.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] count,
    input  logic             load_shadow,
    input  logic             transfer,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             pol_in,
    output logic             pwm
);

    logic [WIDTH-1:0] duty_sh_q, duty_sh_d;
    logic [WIDTH-1:0] duty_act_q, duty_act_d;
    logic             pol_sh_q, pol_sh_d;
    logic             pol_act_q, pol_act_d;
    logic             pwm_q, pwm_d;

    always_comb begin
        duty_sh_d  = duty_sh_q;
        pol_sh_d   = pol_sh_q;
        duty_act_d = duty_act_q;
        pol_act_d  = pol_act_q;
        if (load_shadow) begin
            duty_sh_d = duty_in;
            pol_sh_d  = pol_in;
        end
        // Transfer takes the shadow as it was before this cycle's load.
        if (transfer) begin
            duty_act_d = duty_sh_q;
            pol_act_d  = pol_sh_q;
        end
        if (enable) begin
            pwm_d = (count < duty_act_q) ^ pol_act_q;
        end else begin
            pwm_d = pol_act_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            duty_sh_q  <= '0;
            duty_act_q <= '0;
            pol_sh_q   <= 1'b0;
            pol_act_q  <= 1'b0;
            pwm_q      <= 1'b0;
        end else begin
            duty_sh_q  <= duty_sh_d;
            duty_act_q <= duty_act_d;
            pol_sh_q   <= pol_sh_d;
            pol_act_q  <= pol_act_d;
            pwm_q      <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM: shared edge/center timebase, double-buffered settings.
// Ports: clk, reset, enable, center, period, duty, polarity, update -> pwm, count, period_end, update_pending.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      center,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic [CHANNELS-1:0]       polarity,
    input  logic                      update,
    output logic [CHANNELS-1:0]       pwm,
    output logic [WIDTH-1:0]          count,
    output logic                      period_end,
    output logic                      update_pending
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] per_sh_q, per_sh_d;
    logic [WIDTH-1:0] per_act_q, per_act_d;
    logic             ctr_sh_q, ctr_sh_d;
    logic             ctr_act_q, ctr_act_d;
    logic             pend_q, pend_d;
    logic             pe_q, pe_d;
    logic             boundary;
    logic             transfer;

    always_comb begin
        boundary = 1'b0;
        if (enable) begin
            if (per_act_q == '0) begin
                boundary = 1'b1;
            end else if (ctr_act_q == MODE_EDGE) begin
                boundary = (count_q == per_act_q);
            end else begin
                // With P=1 the peak is also the last down-count value.
                boundary = (count_q == ONE) &&
                           (dir_q == DIR_DOWN || per_act_q == ONE);
            end
        end

        // While disabled the shadow drains every cycle.
        transfer = pend_q && (boundary || !enable);

        count_d = count_q;
        dir_d   = dir_q;
        if (!enable || boundary) begin
            count_d = '0;
            dir_d   = DIR_UP;
        end else if (ctr_act_q == MODE_EDGE) begin
            count_d = count_q + ONE;
            dir_d   = DIR_UP;
        end else if (dir_q == DIR_UP) begin
            if (count_q >= per_act_q) begin
                count_d = count_q - ONE;
                dir_d   = DIR_DOWN;
            end else begin
                count_d = count_q + ONE;
            end
        end else begin
            count_d = count_q - ONE;
        end

        per_sh_d = update ? period : per_sh_q;
        ctr_sh_d = update ? center : ctr_sh_q;

        per_act_d = transfer ? per_sh_q : per_act_q;
        ctr_act_d = transfer ? ctr_sh_q : ctr_act_q;

        if (update) begin
            pend_d = 1'b1;
        end else if (transfer) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end

        pe_d = boundary;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            dir_q     <= DIR_UP;
            per_sh_q  <= '0;
            per_act_q <= '0;
            ctr_sh_q  <= MODE_EDGE;
            ctr_act_q <= MODE_EDGE;
            pend_q    <= 1'b0;
            pe_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            dir_q     <= dir_d;
            per_sh_q  <= per_sh_d;
            per_act_q <= per_act_d;
            ctr_sh_q  <= ctr_sh_d;
            ctr_act_q <= ctr_act_d;
            pend_q    <= pend_d;
            pe_q      <= pe_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .enable     (enable),
            .count      (count_q),
            .load_shadow(update),
            .transfer   (transfer),
            .duty_in    (duty[duty_lsb(i, WIDTH) +: WIDTH]),
            .pol_in     (polarity[i]),
            .pwm        (pwm[i])
        );
    end

    assign count          = count_q;
    assign period_end     = pe_q;
    assign update_pending = pend_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Testbench for pwm_multichannel: table vectors, directed corners, random vs model.
// Drives inputs on the falling edge and samples outputs there too.
module tb_pwm_multichannel;

    localparam int W  = 8;
    localparam int CH = 4;

    logic            clk;
    logic            reset;
    logic            enable;
    logic            center;
    logic [W-1:0]    period;
    logic [CH*W-1:0] duty;
    logic [CH-1:0]   polarity;
    logic            update;
    logic [CH-1:0]   pwm;
    logic [W-1:0]    count;
    logic            period_end;
    logic            update_pending;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 0;

    pwm_multichannel #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .center        (center),
        .period        (period),
        .duty          (duty),
        .polarity      (polarity),
        .update        (update),
        .pwm           (pwm),
        .count         (count),
        .period_end    (period_end),
        .update_pending(update_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the timebase is a phase index t within the period,
    // and count is a plain function of t, period length and mode.
    int         m_t, m_p, m_c, s_p, s_c;
    int         m_d[CH], s_d[CH];
    bit         m_pol[CH], s_pol[CH];
    bit         m_pend, m_pe;
    logic [CH-1:0] m_pwm = '0;

    function automatic int m_len(input int p, input int c);
        if (p == 0) return 1;
        return c ? 2 * p : p + 1;
    endfunction

    function automatic int m_cnt(input int t, input int p, input int c);
        if (c == 0) return t;
        return (t <= p) ? t : 2 * p - t;
    endfunction

    always @(posedge clk) begin : mdl
        int len;
        int cnt;
        bit bnd;
        bit xf;
        if (reset) begin
            m_t = 0; m_p = 0; m_c = 0; s_p = 0; s_c = 0;
            m_pend = 0; m_pe = 0; m_pwm = '0;
            for (int i = 0; i < CH; i++) begin
                m_d[i] = 0; s_d[i] = 0; m_pol[i] = 0; s_pol[i] = 0;
            end
        end else begin
            len = m_len(m_p, m_c);
            cnt = m_cnt(m_t, m_p, m_c);
            bnd = enable && (m_t == len - 1);
            for (int i = 0; i < CH; i++)
                m_pwm[i] = enable ? ((cnt < m_d[i]) ^ m_pol[i]) : m_pol[i];
            m_pe = bnd;
            xf = m_pend && (bnd || !enable);
            m_t = (!enable || bnd) ? 0 : m_t + 1;
            if (xf) begin
                m_p = s_p; m_c = s_c;
                for (int i = 0; i < CH; i++) begin
                    m_d[i] = s_d[i]; m_pol[i] = s_pol[i];
                end
            end
            if (update) begin
                s_p = int'(period); s_c = int'(center);
                for (int i = 0; i < CH; i++) begin
                    s_d[i] = int'(duty[i*W +: W]); s_pol[i] = polarity[i];
                end
            end
            if (update) m_pend = 1;
            else if (xf) m_pend = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (count !== W'(m_cnt(m_t, m_p, m_c)) || pwm !== m_pwm ||
                period_end !== m_pe || update_pending !== m_pend) begin
                miscompares++;
                if (miscompares <= 20)
                    $display("FAIL model t=%0t: count %0d/%0d pwm %b/%b pe %b/%b pend %b/%b",
                             $time, count, m_cnt(m_t, m_p, m_c), pwm, m_pwm,
                             period_end, m_pe, update_pending, m_pend);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cfg(input int p, input int ch, input int d,
                       input bit pol, input bit c);
        reset = 1; enable = 0; update = 0;
        tick();
        reset = 0;
        period = W'(p); center = c;
        duty = '0; duty[ch*W +: W] = W'(d);
        polarity = '0; polarity[ch] = pol;
        update = 1;
        tick();
        update = 0;
        tick();
    endtask

    task automatic wait_pe();
        int k = 0;
        do begin tick(); k++; end while (!period_end && k < 1000);
        if (!period_end) chk("pe_timeout", 0, 1);
    endtask

    task automatic measure(input int ch, output int n, output int hi);
        wait_pe();
        n = 0; hi = 0;
        do begin tick(); n++; hi += int'(pwm[ch]); end
        while (!period_end && n < 1000);
    endtask

    typedef struct {
        int p; int d; bit pol; bit c; int ch; int exp_len; int exp_hi;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int n, hi, hi2, hi3;
        bit pend_ok;

        tbl[0]  = '{9, 3, 0, 0, 0, 10, 3};
        tbl[1]  = '{8, 4, 0, 1, 1, 16, 7};
        tbl[2]  = '{5, 0, 0, 0, 2, 6, 0};
        tbl[3]  = '{5, 6, 0, 0, 2, 6, 6};
        tbl[4]  = '{5, 255, 0, 0, 3, 6, 6};
        tbl[5]  = '{5, 0, 1, 0, 2, 6, 6};
        tbl[6]  = '{5, 6, 1, 0, 2, 6, 0};
        tbl[7]  = '{5, 255, 1, 0, 3, 6, 0};
        tbl[8]  = '{0, 1, 0, 0, 0, 1, 1};
        tbl[9]  = '{0, 0, 0, 1, 0, 1, 0};
        tbl[10] = '{5, 6, 0, 1, 1, 10, 10};
        tbl[11] = '{3, 2, 0, 1, 0, 6, 3};
        tbl[12] = '{1, 1, 0, 1, 2, 2, 1};

        reset = 1; enable = 0; center = 0; period = '0;
        duty = '0; polarity = '0; update = 0;
        tick();
        chk_en = 1;
        chk("rst_count", int'(count), 0);
        chk("rst_pwm", int'(pwm), 0);
        chk("rst_pe", int'(period_end), 0);
        chk("rst_pend", int'(update_pending), 0);

        foreach (tbl[i]) begin
            cfg(tbl[i].p, tbl[i].ch, tbl[i].d, tbl[i].pol, tbl[i].c);
            enable = 1;
            measure(tbl[i].ch, n, hi);
            chk($sformatf("tbl%0d_len", i), n, tbl[i].exp_len);
            chk($sformatf("tbl%0d_hi", i), hi, tbl[i].exp_hi);
        end

        // Mid-period duty change 2 -> 7 at count 4.
        cfg(9, 0, 2, 0, 0);
        enable = 1;
        wait_pe();
        hi = 0; pend_ok = 1;
        for (int j = 1; j <= 10; j++) begin
            tick();
            update = 0;
            hi += int'(pwm[0]);
            if (j >= 5 && j <= 9) pend_ok &= update_pending;
            if (j == 4) begin
                chk("mid_cnt4", int'(count), 4);
                duty[7:0] = 8'd7; update = 1;
            end
        end
        chk("mid_old_hi", hi, 2);
        chk("mid_pend_hold", int'(pend_ok), 1);
        chk("mid_pe", int'(period_end), 1);
        chk("mid_pend_clr", int'(update_pending), 0);
        hi2 = 0;
        for (int j = 1; j <= 10; j++) begin
            tick(); hi2 += int'(pwm[0]);
        end
        chk("mid_new_hi", hi2, 7);

        // Update coincident with the boundary.
        cfg(9, 0, 2, 0, 0);
        enable = 1;
        wait_pe();
        hi = 0;
        for (int j = 1; j <= 10; j++) begin
            tick();
            update = 0;
            hi += int'(pwm[0]);
            if (j == 3) begin duty[7:0] = 8'd5; update = 1; end
            if (j == 9) begin
                chk("same_cnt9", int'(count), 9);
                duty[7:0] = 8'd8; update = 1;
            end
        end
        chk("same_p1_hi", hi, 2);
        chk("same_pend_kept", int'(update_pending), 1);
        hi2 = 0; pend_ok = 1;
        for (int j = 1; j <= 10; j++) begin
            tick();
            hi2 += int'(pwm[0]);
            if (j <= 9) pend_ok &= update_pending;
        end
        chk("same_p2_hi", hi2, 5);
        chk("same_p2_pend", int'(pend_ok), 1);
        chk("same_p2_pend_clr", int'(update_pending), 0);
        hi3 = 0;
        for (int j = 1; j <= 10; j++) begin
            tick(); hi3 += int'(pwm[0]);
        end
        chk("same_p3_hi", hi3, 8);

        // Enable dropped mid-period with an update while disabled.
        cfg(9, 0, 3, 1, 0);
        enable = 1;
        wait_pe();
        for (int k = 0; k < 20 && count != 8'd5; k++) tick();
        chk("dis_cnt5", int'(count), 5);
        enable = 0; duty[7:0] = 8'd6; polarity = '0; update = 1;
        tick();
        update = 0;
        chk("dis_count0", int'(count), 0);
        chk("dis_pwm_pol", int'(pwm[0]), 1);
        chk("dis_pe", int'(period_end), 0);
        tick();
        chk("dis_pend_clr", int'(update_pending), 0);
        tick();
        chk("dis_pwm_newpol", int'(pwm[0]), 0);
        enable = 1;
        tick();
        chk("reen_cnt1", int'(count), 1);
        measure(0, n, hi);
        chk("reen_len", n, 10);
        chk("reen_hi", hi, 6);

        // Reset mid-period with an update pending.
        cfg(9, 0, 3, 0, 0);
        enable = 1;
        wait_pe();
        tick(); tick(); tick();
        duty[7:0] = 8'd7; update = 1;
        tick();
        update = 0;
        chk("rstm_pend", int'(update_pending), 1);
        reset = 1;
        tick();
        chk("rstm_count", int'(count), 0);
        chk("rstm_pwm", int'(pwm), 0);
        chk("rstm_pe", int'(period_end), 0);
        chk("rstm_pend", int'(update_pending), 0);
        reset = 0;

        // Random traffic against the model.
        enable = 1;
        for (int k = 0; k < 4000; k++) begin
            tick();
            reset  = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            update = ($urandom_range(0, 11) == 0);
            if (update) begin
                period = W'($urandom_range(0, 12));
                center = 1'($urandom_range(0, 1));
                polarity = CH'($urandom);
                for (int i = 0; i < CH; i++)
                    duty[i*W +: W] = ($urandom_range(0, 7) == 0) ?
                        8'd255 : W'($urandom_range(0, 14));
            end
        end
        reset = 0; update = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
